// File: rtl/idli_sqi_ctrl_m.sv
// SQI SRAM sequencer: cmd, address, dummy (read), then a handshaked nibble stream.
// Define IDLI_SQI_EQIO_EN to send EQIO (0x38) on SIO[0] after reset, before going idle.
module idli_sqi_ctrl_m #(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DUMMY_NIBBLES = 2
) (
  input  logic              i_sqi_gck,
  input  logic              i_sqi_rst_n,
  input  logic              i_sqi_req,
  input  logic              i_sqi_wr,
  input  logic [ADDR_W-1:0] i_sqi_addr,
  output logic              o_sqi_busy,
  input  logic [3:0]        i_sqi_wdata,
  input  logic              i_sqi_wvld,
  output logic              o_sqi_wacp,
  output logic [3:0]        o_sqi_rdata,
  output logic              o_sqi_rvld,
  input  logic              i_sqi_racp,
  output logic              o_sqi_sck,
  output logic              o_sqi_cs,
  output logic              o_sqi_io_mode,
  input  logic [3:0]        i_sqi_sio,
  output logic [3:0]        o_sqi_sio
);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StDummy,
    StData,
    StEnd,
    StInit
  } state_e;

  localparam logic [7:0] CmdLast   = 8'd1;
  localparam logic [7:0] AddrLast  = 8'(ADDR_W / 4 - 1);
  localparam logic [7:0] DummyLast = 8'((DUMMY_NIBBLES > 0) ? DUMMY_NIBBLES - 1 : 0);
  localparam logic [7:0] InitLast  = 8'd7;
  localparam logic [7:0] EndLast   = 8'd1;

`ifdef IDLI_SQI_EQIO_EN
  localparam state_e StReset = StInit;
`else
  localparam state_e StReset = StIdle;
`endif

  state_e            state_q, state_d;
  logic              phase_q, phase_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              par_q, par_d;
  logic [3:0]        wdata_q, wdata_d;
  logic [3:0]        rdata_q, rdata_d;
  logic              rvld_q, rvld_d;

  logic              capture;
  logic              wacp;
  logic              stream_end;
  logic              rd_ready;
  logic [7:0]        seq_last;
  state_e            seq_next;

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      state_q <= StReset;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      par_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      par_q   <= par_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
    end
  end

  // Length and successor of the fixed-length header states.
  always_comb begin
    seq_last = CmdLast;
    seq_next = StAddr;
    case (state_q)
      StAddr: begin
        seq_last = AddrLast;
        seq_next = (wr_q || (DUMMY_NIBBLES == 0)) ? StData : StDummy;
      end
      StDummy: begin
        seq_last = DummyLast;
        seq_next = StData;
      end
      StInit: begin
        seq_last = InitLast;
        seq_next = StEnd;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    par_d      = par_q;
    wdata_d    = wdata_q;
    capture    = 1'b0;
    wacp       = 1'b0;
    // The stream may only stop on a byte boundary.
    stream_end = !i_sqi_req && !par_q;
    rd_ready   = !rvld_q || i_sqi_racp;

    unique case (state_q)
      StIdle: begin
        if (i_sqi_req) begin
          state_d = StCmd;
          wr_d    = i_sqi_wr;
          addr_d  = i_sqi_addr;
          cnt_d   = '0;
          phase_d = 1'b0;
          par_d   = 1'b0;
        end
      end
      StCmd, StAddr, StDummy, StInit: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          cnt_d   = cnt_q + 8'd1;
          if (state_q == StAddr) begin
            addr_d = addr_q << 4;
          end
          if (cnt_q == seq_last) begin
            cnt_d   = '0;
            state_d = seq_next;
          end
        end
      end
      StData: begin
        if (!phase_q) begin
          if (wr_q) begin
            if (stream_end) begin
              state_d = StEnd;
              cnt_d   = '0;
            end else if (i_sqi_wvld) begin
              wacp    = 1'b1;
              wdata_d = i_sqi_wdata;
              phase_d = 1'b1;
            end
          end else if (rd_ready) begin
            if (stream_end) begin
              state_d = StEnd;
              cnt_d   = '0;
            end else begin
              capture = 1'b1;
              phase_d = 1'b1;
            end
          end
        end else begin
          phase_d = 1'b0;
          par_d   = ~par_q;
        end
      end
      StEnd: begin
        if (cnt_q == EndLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        phase_d = 1'b0;
      end
    endcase

    rdata_d = capture ? i_sqi_sio : rdata_q;
    rvld_d  = capture ? 1'b1 : (rvld_q && !i_sqi_racp);
  end

`ifdef IDLI_SQI_EQIO_EN
  logic [7:0] eqio_sh;
  assign eqio_sh = 8'h38 << cnt_q[2:0];
`endif

  always_comb begin
    o_sqi_sio     = 4'h0;
    o_sqi_io_mode = 1'b1;
    o_sqi_cs      = 1'b0;
    unique case (state_q)
      StIdle, StEnd: o_sqi_cs = 1'b1;
      StCmd: begin
        o_sqi_io_mode = 1'b0;
        o_sqi_sio     = cnt_q[0] ? {3'b001, ~wr_q} : 4'h0;
      end
      StAddr: begin
        o_sqi_io_mode = 1'b0;
        o_sqi_sio     = addr_q[ADDR_W-1 -: 4];
      end
      StData: begin
        if (wr_q) begin
          o_sqi_io_mode = 1'b0;
          o_sqi_sio     = wdata_q;
        end
      end
      StInit: begin
        o_sqi_io_mode = 1'b0;
`ifdef IDLI_SQI_EQIO_EN
        o_sqi_sio     = {3'b000, eqio_sh[7]};
`endif
      end
      default: ;
    endcase
  end

  assign o_sqi_sck   = phase_q;
  assign o_sqi_busy  = (state_q != StIdle);
  assign o_sqi_wacp  = wacp;
  assign o_sqi_rdata = rdata_q;
  assign o_sqi_rvld  = rvld_q;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Bench for idli_sqi_ctrl_m: slot-level scoreboard plus directed latency/stall/reset checks.
module tb_idli_sqi_ctrl_m;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req   = 1'b0;
  logic        wr    = 1'b0;
  logic [15:0] addr  = '0;
  logic [3:0]  wdata = '0;
  logic        wvld  = 1'b0;
  logic        racp  = 1'b0;
  logic [3:0]  sio_in = '0;

  logic       busy, wacp, rvld, sck, cs, io_mode;
  logic [3:0] rdata, sio_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idli_sqi_ctrl_m dut (
    .i_sqi_gck     (clk),
    .i_sqi_rst_n   (rst_n),
    .i_sqi_req     (req),
    .i_sqi_wr      (wr),
    .i_sqi_addr    (addr),
    .o_sqi_busy    (busy),
    .i_sqi_wdata   (wdata),
    .i_sqi_wvld    (wvld),
    .o_sqi_wacp    (wacp),
    .o_sqi_rdata   (rdata),
    .o_sqi_rvld    (rvld),
    .i_sqi_racp    (racp),
    .o_sqi_sck     (sck),
    .o_sqi_cs      (cs),
    .o_sqi_io_mode (io_mode),
    .i_sqi_sio     (sio_in),
    .o_sqi_sio     (sio_out)
  );

  typedef struct {
    logic       io;
    logic [3:0] sio;
    logic       chk;
  } slot_t;

  slot_t      slots[$];
  logic [3:0] wd_list[$];

  // Read data the SRAM returns for data nibble j of any read.
  function automatic logic [3:0] rd_nib(input int j);
    return 4'((j * 7 + 5) % 16);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected SCK slots for one transaction.
  task automatic push_model(input logic w, input logic [15:0] a, input int n);
    slot_t s;
    s = '{io: 1'b0, sio: 4'h0, chk: 1'b1};
    slots.push_back(s);
    s.sio = w ? 4'h2 : 4'h3;
    slots.push_back(s);
    for (int i = 0; i < 4; i++) begin
      s.sio = a[15 - 4 * i -: 4];
      slots.push_back(s);
    end
    if (!w) begin
      for (int i = 0; i < 2; i++) begin
        s = '{io: 1'b1, sio: 4'h0, chk: 1'b1};
        slots.push_back(s);
      end
    end
    for (int i = 0; i < n; i++) begin
      if (w) s = '{io: 1'b0, sio: wd_list[i], chk: 1'b1};
      else   s = '{io: 1'b1, sio: 4'h0, chk: 1'b0};
      slots.push_back(s);
    end
  endtask

  // SRAM side: after each SCK rise present the nibble for the next slot.
  initial begin : sram
    int  slot;
    logic prev;
    slot = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || cs) begin
        slot = 0;
        prev = 1'b0;
      end else begin
        if (sck && !prev) slot++;
        prev = sck;
      end
      sio_in = (slot >= 8) ? rd_nib(slot - 8) : 4'h0;
    end
  end

  // Compare process: every SCK rise consumes one expected slot; every read handshake one nibble.
  initial begin : cmp
    logic  prev_sck, prev_busy;
    int    rd_idx;
    slot_t s;
    prev_sck  = 1'b0;
    prev_busy = 1'b0;
    rd_idx    = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        slots.delete();
        prev_sck  = 1'b0;
        prev_busy = 1'b0;
        rd_idx    = 0;
      end else begin
        if (busy && !prev_busy) rd_idx = 0;
        if (sck && !prev_sck) begin
          if (slots.size() == 0) begin
            check("extra_slot", 1, 0);
          end else begin
            s = slots.pop_front();
            check("slot_io_mode", io_mode, s.io);
            if (s.chk) check("slot_sio", sio_out, s.sio);
            check("slot_cs", cs, 0);
          end
        end
        if (rvld && racp) begin
          check("rdata", rdata, rd_nib(rd_idx));
          rd_idx++;
        end
        if (!busy && prev_busy) check("slots_left", slots.size(), 0);
        prev_sck  = sck;
        prev_busy = busy;
      end
    end
  end

  int         first_wacp, first_rvld, end_high, hs_n, stall_cnt, stall_bad;
  logic [3:0] first_rd;
  logic [3:0] sio_log[16];
  logic       io_log[16];
  logic       cs_log[16];

  // Runs one transaction from idle; caller is just after a rising edge.
  task automatic run_txn(input logic w, input logic [15:0] a, input int n, input int drop,
                         input int stall);
    int   k;
    logic done, busy_seen, hs, rd_seen;
    push_model(w, a, n);
    wr    = w;
    addr  = a;
    req   = 1'b1;
    wvld  = w;
    wdata = w ? wd_list[0] : 4'h0;
    racp  = (stall == 0);
    k = 0; done = 1'b0; busy_seen = 1'b0; rd_seen = 1'b0;
    first_wacp = -1; first_rvld = -1; end_high = 0; hs_n = 0;
    stall_cnt = 0; stall_bad = 0; first_rd = 4'h0;
    while (!done && k < 300) begin
      @(negedge clk);
      if (w && wacp && first_wacp < 0) first_wacp = k;
      if (!w && rvld && first_rvld < 0) first_rvld = k;
      if (!w && rvld && !rd_seen) begin
        first_rd = rdata;
        rd_seen  = 1'b1;
      end
      if (k < 16) begin
        sio_log[k] = sio_out;
        io_log[k]  = io_mode;
        cs_log[k]  = cs;
      end
      if (busy) busy_seen = 1'b1;
      if (busy_seen && busy && cs) end_high++;
      hs = w ? wacp : (rvld && racp);
      if (stall > 0 && rvld && !racp) begin
        stall_cnt++;
        if (stall_cnt > 1 && (sck || rdata != first_rd)) stall_bad++;
      end
      if (busy_seen && !busy) done = 1'b1;
      @(posedge clk);
      #1;
      k++;
      if (hs) begin
        hs_n++;
        if (w && hs_n < wd_list.size()) wdata = wd_list[hs_n];
        if (hs_n == drop) req = 1'b0;
      end
      if (stall > 0 && stall_cnt >= stall) racp = 1'b1;
    end
    check("txn_done", done, 1);
    req  = 1'b0;
    wvld = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin : main
    #1 rst_n = 1'b0;
    #1;
    check("rst_sck", sck, 0);
    check("rst_cs", cs, 1);
    check("rst_io_mode", io_mode, 1);
    check("rst_sio", sio_out, 0);
    check("rst_busy", busy, 0);
    check("rst_rvld", rvld, 0);
    check("rst_rdata", rdata, 0);
    check("rst_wacp", wacp, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Read 0x1234, racp tied high.
    run_txn(1'b0, 16'h1234, 4, 4, 0);
    check("rd_cs_cycle0", cs_log[0], 1);
    check("rd_cs_cycle1", cs_log[1], 0);
    check("rd_sio_c2", sio_log[2], 4'h0);
    check("rd_sio_c4", sio_log[4], 4'h3);
    check("rd_sio_c6", sio_log[6], 4'h1);
    check("rd_sio_c8", sio_log[8], 4'h2);
    check("rd_sio_c10", sio_log[10], 4'h3);
    check("rd_sio_c12", sio_log[12], 4'h4);
    check("rd_io_c12", io_log[12], 0);
    check("rd_io_c13", io_log[13], 1);
    check("rd_first_rvld", first_rvld, 18);
    check("rd_first_data", first_rd, 4'h5);
    check("rd_count", hs_n, 4);
    repeat (3) @(posedge clk);
    #1;

    // Write 0xBEEF with A,5,C,3.
    wd_list = '{4'hA, 4'h5, 4'hC, 4'h3};
    run_txn(1'b1, 16'hBEEF, 4, 4, 0);
    check("wr_first_wacp", first_wacp, 13);
    check("wr_sio_c4", sio_log[4], 4'h2);
    check("wr_sio_c6", sio_log[6], 4'hB);
    check("wr_io_c13", io_log[13], 0);
    check("wr_count", hs_n, 4);
    check("wr_end_cycles", end_high, 2);
    repeat (2) @(posedge clk);
    #1;

    // req dropped after an odd count: the fourth nibble still goes out.
    wd_list = '{4'h1, 4'h2, 4'h3, 4'h4};
    run_txn(1'b1, 16'h0102, 4, 3, 0);
    check("odd_drop_count", hs_n, 4);
    check("odd_drop_end_cycles", end_high, 2);
    repeat (2) @(posedge clk);
    #1;

    // Read with racp low for 10 cycles.
    run_txn(1'b0, 16'h0040, 2, 2, 10);
    check("stall_first_rvld", first_rvld, 18);
    check("stall_cycles", stall_cnt, 10);
    check("stall_unstable", stall_bad, 0);
    check("stall_first_data", first_rd, 4'h5);
    check("stall_count", hs_n, 2);
    repeat (2) @(posedge clk);
    #1;

    // Async reset in the middle of the address phase.
    wd_list = '{4'h0};
    push_model(1'b1, 16'hABCD, 0);
    wr   = 1'b1;
    addr = 16'hABCD;
    wvld = 1'b1;
    req  = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("pre_rst_cs", cs, 0);
    check("pre_rst_sck", sck, 1);
    check("pre_rst_io", io_mode, 0);
    #2;
    rst_n = 1'b0;
    req   = 1'b0;
    wvld  = 1'b0;
    #1;
    check("arst_cs", cs, 1);
    check("arst_io_mode", io_mode, 1);
    check("arst_sck", sck, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Next request starts again from the command.
    run_txn(1'b0, 16'h00F0, 2, 2, 0);
    check("post_rst_sio_c2", sio_log[2], 4'h0);
    check("post_rst_sio_c4", sio_log[4], 4'h3);
    check("post_rst_sio_c12", sio_log[12], 4'h0);
    check("post_rst_first_rvld", first_rvld, 18);
    check("post_rst_count", hs_n, 2);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
